dsv_row_pair_sched: RTL and testbench

DSV_ROW_PAIR_SCHED -- requirements
Module: dsv_row_pair_sched

---
 rtl/dsv_row_pair_sched.sv | 173 +++++++++++++++++
 tb/tb_dsv_row_pair_sched.sv | 350 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/dsv_row_pair_sched.sv
// -----------------------------------------------------------------------------
// dsv_row_pair_sched
//
// Converts a raster pixel stream into vertical pixel pairs for a 2x1
// vertical filter. Even rows are stored in a one-line buffer. Each pixel
// of the following odd row is registered together with the buffered pixel
// above it, giving one output window per odd-row pixel with a latency of
// one cycle.
//
// Optional build macro:
//   DSV_ROW_PAIR_SCHED_SEQ_CHK_EN - track the expected (col,row) sequence.
//     A beat with unexpected coordinates sets the sticky error_o flag,
//     returns the block to IDLE and produces no output. While error_o is
//     set, no new frame is accepted. Without the macro the coordinates are
//     trusted and error_o is tied 0.
//
// Ports:
//   clk_i, rst_i        clock (rising edge), asynchronous active-low reset
//   width_i, height_i   frame size, latched when a frame starts
//   data_i, col_i,      raster pixel and its coordinates, qualified by
//   row_i, valid_i      valid_i (no backpressure)
//   window_o[2][1]      vertical pair: [0] = even-row pixel, [1] = odd-row
//   kernel_o[2][1]      constant tap weights (KERNEL_TAP)
//   col_o, row_o        output coordinates (row_o = odd input row >> 1)
//   valid_o             window_o qualifier
//   frame_done_o        one-cycle pulse after the last pixel of a frame
//   error_o             sticky coordinate-sequence error
// -----------------------------------------------------------------------------
module dsv_row_pair_sched #(
  parameter int                       FP_WIDTH_REG = 16,
  parameter int                       MAX_WIDTH    = 1024,
  parameter logic [FP_WIDTH_REG-1:0]  KERNEL_TAP   = 16'h3800
) (
  input  logic                     clk_i,
  input  logic                     rst_i,
  input  logic [15:0]              width_i,
  input  logic [15:0]              height_i,
  input  logic [FP_WIDTH_REG-1:0]  data_i,
  input  logic [15:0]              col_i,
  input  logic [15:0]              row_i,
  input  logic                     valid_i,
  output logic [FP_WIDTH_REG-1:0]  window_o [2][1],
  output logic [FP_WIDTH_REG-1:0]  kernel_o [2][1],
  output logic [15:0]              col_o,
  output logic [15:0]              row_o,
  output logic                     valid_o,
  output logic                     frame_done_o,
  output logic                     error_o
);

  localparam int ADDR_W = (MAX_WIDTH > 1) ? $clog2(MAX_WIDTH) : 1;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_FILL = 2'd1;  // even row: store into line buffer
  localparam logic [1:0] ST_PAIR = 2'd2;  // odd row: emit pairs

  logic [1:0]              state_q, state_d;
  logic [15:0]             width_q, height_q;
  logic [15:0]             cur_width, cur_height;
  logic                    start, beat, seq_bad;
  logic                    row_end, frame_end;
  logic                    wr_en, pair_out;
  logic [ADDR_W-1:0]       col_idx;
  logic [FP_WIDTH_REG-1:0] linebuf [MAX_WIDTH];

`ifdef DSV_ROW_PAIR_SCHED_SEQ_CHK_EN
  logic [15:0] exp_col_q, exp_row_q;
  logic        err_q;
`endif

  assign col_idx = col_i[ADDR_W-1:0];

  assign kernel_o[0][0] = KERNEL_TAP;
  assign kernel_o[1][0] = KERNEL_TAP;

  // NOTE: every signal written here gets a default first, so no path can
  // leave it unassigned and infer a latch.
  always_comb begin
`ifdef DSV_ROW_PAIR_SCHED_SEQ_CHK_EN
    start   = (state_q == ST_IDLE) && valid_i && (col_i == 16'd0) &&
              (row_i == 16'd0) && !err_q;
    seq_bad = (state_q != ST_IDLE) && valid_i &&
              ((col_i != exp_col_q) || (row_i != exp_row_q));
`else
    start   = (state_q == ST_IDLE) && valid_i && (col_i == 16'd0) &&
              (row_i == 16'd0);
    seq_bad = 1'b0;
`endif
    beat = (state_q != ST_IDLE) && valid_i && !seq_bad;

    // The starting pixel is also the first pixel of the even row, so it is
    // judged against the sizes being latched on the same edge.
    cur_width  = start ? width_i  : width_q;
    cur_height = start ? height_i : height_q;
    row_end    = (col_i == cur_width - 16'd1);
    frame_end  = row_end && (row_i == cur_height - 16'd1);

    wr_en    = start || (beat && (state_q == ST_FILL));
    pair_out = beat && (state_q == ST_PAIR);

    state_d = state_q;
    if (seq_bad) begin
      state_d = ST_IDLE;
    end else if (start || beat) begin
      if (frame_end)
        state_d = ST_IDLE;
      else if (row_end)
        state_d = (state_q == ST_PAIR) ? ST_FILL : ST_PAIR;
      else if (start)
        state_d = ST_FILL;
    end
  end

  // NOTE: sequential state uses non-blocking assignments only, so every
  // register samples the pre-edge values regardless of statement order.
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      state_q        <= ST_IDLE;
      width_q        <= 16'd0;
      height_q       <= 16'd0;
      valid_o        <= 1'b0;
      frame_done_o   <= 1'b0;
      col_o          <= 16'd0;
      row_o          <= 16'd0;
      window_o[0][0] <= '0;
      window_o[1][0] <= '0;
    end else begin
      state_q      <= state_d;
      valid_o      <= pair_out;
      frame_done_o <= (start || beat) && frame_end;
      if (start) begin
        width_q  <= width_i;
        height_q <= height_i;
      end
      if (pair_out) begin
        window_o[0][0] <= linebuf[col_idx];
        window_o[1][0] <= data_i;
        col_o          <= col_i;
        row_o          <= row_i >> 1;
      end
    end
  end

  // NOTE: the line buffer has no reset; each entry is written in an even row
  // before the odd row reads it, and a reset-free array maps onto RAM.
  always_ff @(posedge clk_i) begin
    if (wr_en)
      linebuf[col_idx] <= data_i;
  end

`ifdef DSV_ROW_PAIR_SCHED_SEQ_CHK_EN
  // Expected next coordinate follows raster order from the accepted beat.
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      exp_col_q <= 16'd0;
      exp_row_q <= 16'd0;
      err_q     <= 1'b0;
    end else begin
      if (seq_bad)
        err_q <= 1'b1;
      if (start || beat) begin
        exp_col_q <= row_end ? 16'd0 : col_i + 16'd1;
        exp_row_q <= row_end ? row_i + 16'd1 : row_i;
      end
    end
  end

  assign error_o = err_q;
`else
  assign error_o = 1'b0;
`endif

endmodule

// File: tb/tb_dsv_row_pair_sched.sv
// -----------------------------------------------------------------------------
// tb_dsv_row_pair_sched
//
// Self-checking bench for dsv_row_pair_sched. A frame-level reference model
// keeps every pixel of the current frame in an array; each odd-row pixel is
// expected one cycle later as {pixel directly above, pixel}. Outputs are
// sampled on the falling clock edge.
// -----------------------------------------------------------------------------
module tb_dsv_row_pair_sched;

  localparam int MAXW = 1024;

  logic        clk_i = 1'b0;
  logic        rst_i;
  logic [15:0] width_i, height_i, data_i, col_i, row_i;
  logic        valid_i;
  logic [15:0] window_o [2][1];
  logic [15:0] kernel_o [2][1];
  logic [15:0] col_o, row_o;
  logic        valid_o, frame_done_o, error_o;

  dsv_row_pair_sched #(
    .FP_WIDTH_REG (16),
    .MAX_WIDTH    (MAXW),
    .KERNEL_TAP   (16'h3800)
  ) dut (
    .clk_i        (clk_i),
    .rst_i        (rst_i),
    .width_i      (width_i),
    .height_i     (height_i),
    .data_i       (data_i),
    .col_i        (col_i),
    .row_i        (row_i),
    .valid_i      (valid_i),
    .window_o     (window_o),
    .kernel_o     (kernel_o),
    .col_o        (col_o),
    .row_o        (row_o),
    .valid_o      (valid_o),
    .frame_done_o (frame_done_o),
    .error_o      (error_o)
  );

  always #5 clk_i = ~clk_i;

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model state
  bit          m_active = 1'b0;
  int          mw, mh;
  logic [15:0] m_px [];

  // Observation counters for the current frame
  int          obs_valid, obs_done;
  logic [15:0] win21_0, win21_1;
  bit          seen21;

  function automatic logic [15:0] to_fp16(input int v);
    int e;
    logic [15:0] r;
    if (v == 0) return 16'h0000;
    e = 0;
    for (int i = 0; i < 11; i++)
      if ((v >> i) != 0) e = i;
    r = {1'b0, 5'(e + 15), 10'((v << (10 - e)) & 'h3ff)};
    return r;
  endfunction

  // One clock cycle: drive inputs, predict, then sample on the falling edge.
  task automatic step(input logic v, input logic [15:0] c, input logic [15:0] r,
                      input logic [15:0] d, input logic [15:0] w_in,
                      input logic [15:0] h_in);
    logic        ev, ed;
    logic [15:0] ew0, ew1, ec, er;
    int          idx;
    valid_i = v; col_i = c; row_i = r; data_i = d;
    width_i = w_in; height_i = h_in;
    ev = 1'b0; ed = 1'b0; ew0 = '0; ew1 = '0; ec = '0; er = '0;
    if (v) begin
      if (!m_active && c == 16'd0 && r == 16'd0) begin
        m_active = 1'b1;
        mw = int'(w_in);
        mh = int'(h_in);
        m_px = new[mw * mh];
      end
      if (m_active) begin
        idx = int'(r) * mw + int'(c);
        m_px[idx] = d;
        if (r[0]) begin
          ev = 1'b1; ew0 = m_px[idx - mw]; ew1 = d; ec = c; er = r / 2;
        end
        if (int'(c) == mw - 1 && int'(r) == mh - 1) begin
          ed = 1'b1;
          m_active = 1'b0;
        end
      end
    end
    @(posedge clk_i);
    @(negedge clk_i);
    n_checks++;
    if (valid_o !== ev) begin
      n_fail++;
      $display("FAIL valid_o after (%0d,%0d): got %b expected %b", c, r, valid_o, ev);
    end
    if (ev) begin
      n_checks++;
      if (window_o[0][0] !== ew0 || window_o[1][0] !== ew1) begin
        n_fail++;
        $display("FAIL window_o after (%0d,%0d): got {%h,%h} expected {%h,%h}",
                 c, r, window_o[0][0], window_o[1][0], ew0, ew1);
      end
      n_checks++;
      if (col_o !== ec || row_o !== er) begin
        n_fail++;
        $display("FAIL coord_o after (%0d,%0d): got (%0d,%0d) expected (%0d,%0d)",
                 c, r, col_o, row_o, ec, er);
      end
    end
    n_checks++;
    if (frame_done_o !== ed) begin
      n_fail++;
      $display("FAIL frame_done_o after (%0d,%0d): got %b expected %b", c, r, frame_done_o, ed);
    end
    n_checks++;
    if (kernel_o[0][0] !== 16'h3800 || kernel_o[1][0] !== 16'h3800) begin
      n_fail++;
      $display("FAIL kernel_o: got {%h,%h} expected {3800,3800}", kernel_o[0][0], kernel_o[1][0]);
    end
    n_checks++;
    if (error_o !== 1'b0) begin
      n_fail++;
      $display("FAIL error_o: got %b expected 0", error_o);
    end
    if (valid_o === 1'b1) obs_valid++;
    if (frame_done_o === 1'b1) obs_done++;
    if (valid_o === 1'b1 && col_o == 16'd2 && row_o == 16'd1) begin
      seen21 = 1'b1; win21_0 = window_o[0][0]; win21_1 = window_o[1][0];
    end
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++)
      step(1'b0, 16'($urandom), 16'($urandom), 16'($urandom), 16'($urandom), 16'($urandom));
  endtask

  // Drives one whole frame. mode: 0 continuous, 1 toggling valid, 2 random gaps.
  task automatic run_frame(input int w, input int h, input int mode, input bit fp_pix,
                           input string name);
    logic [15:0] d;
    bit          first;
    obs_valid = 0; obs_done = 0; first = 1'b1;
    for (int r = 0; r < h; r++) begin
      for (int c = 0; c < w; c++) begin
        if (!first) begin
          if (mode == 1) idle(1);
          else if (mode == 2 && $urandom_range(0, 2) == 0) idle($urandom_range(1, 2));
        end
        d = fp_pix ? to_fp16(r * 4 + c) : 16'($urandom);
        // Sizes are only meaningful on the first beat; later values are junk.
        if (first) step(1'b1, 16'(c), 16'(r), d, 16'(w), 16'(h));
        else       step(1'b1, 16'(c), 16'(r), d, 16'($urandom), 16'($urandom));
        first = 1'b0;
      end
    end
    n_checks++;
    if (obs_valid != w * (h / 2)) begin
      n_fail++;
      $display("FAIL %s valid_o count: got %0d expected %0d", name, obs_valid, w * (h / 2));
    end
    n_checks++;
    if (obs_done != 1) begin
      n_fail++;
      $display("FAIL %s frame_done_o count: got %0d expected 1", name, obs_done);
    end
  endtask

  task automatic test_reset;
    rst_i = 1'b0;
    #1;
    n_checks++;
    if (valid_o !== 1'b0 || frame_done_o !== 1'b0 || error_o !== 1'b0 ||
        col_o !== 16'd0 || row_o !== 16'd0 ||
        window_o[0][0] !== 16'd0 || window_o[1][0] !== 16'd0) begin
      n_fail++;
      $display("FAIL reset_state: got v=%b d=%b e=%b col=%0d row=%0d win={%h,%h} expected all 0",
               valid_o, frame_done_o, error_o, col_o, row_o, window_o[0][0], window_o[1][0]);
    end
    n_checks++;
    if (kernel_o[0][0] !== 16'h3800 || kernel_o[1][0] !== 16'h3800) begin
      n_fail++;
      $display("FAIL reset_kernel: got {%h,%h} expected {3800,3800}", kernel_o[0][0], kernel_o[1][0]);
    end
    repeat (2) @(negedge clk_i);
    rst_i = 1'b1;
    m_active = 1'b0;
    idle(2);
  endtask

  task automatic test_frame_4x4;
    seen21 = 1'b0;
    run_frame(4, 4, 0, 1'b1, "frame_4x4");
    n_checks++;
    if (!seen21 || win21_0 !== 16'h4900 || win21_1 !== 16'h4B00) begin
      n_fail++;
      $display("FAIL window_c2_r1: seen=%b got {%h,%h} expected {4900,4b00}",
               seen21, win21_0, win21_1);
    end
    idle(2);
  endtask

  task automatic test_odd_height;
    run_frame(4, 3, 0, 1'b1, "frame_4x3");
    idle(4);
    n_checks++;
    if (obs_valid != 4) begin
      n_fail++;
      $display("FAIL odd_height_trailing valid_o: got %0d expected 4", obs_valid);
    end
  endtask

  task automatic test_toggle;
    run_frame(2, 2, 1, 1'b0, "toggle_2x2");
    idle(2);
  endtask

  task automatic test_idle_discard;
    step(1'b1, 16'd1, 16'd0, 16'h1234, 16'd2, 16'd2);
    step(1'b1, 16'd0, 16'd1, 16'h2345, 16'd2, 16'd2);
    step(1'b1, 16'd5, 16'd3, 16'h3456, 16'd2, 16'd2);
    run_frame(3, 2, 0, 1'b0, "after_discard");
    idle(1);
  endtask

  task automatic test_reset_mid_frame;
    for (int c = 0; c < 4; c++)
      step(1'b1, 16'(c), 16'd0, 16'($urandom), 16'd4, 16'd4);
    step(1'b1, 16'd0, 16'd1, 16'($urandom), 16'd4, 16'd4);
    // valid_o is high from pixel (0,1) now; reset arrives with pixel (1,1).
    valid_i = 1'b1; col_i = 16'd1; row_i = 16'd1; data_i = 16'h7777;
    #1 rst_i = 1'b0;
    #1;
    n_checks++;
    if (valid_o !== 1'b0 || frame_done_o !== 1'b0 || col_o !== 16'd0 ||
        row_o !== 16'd0 || window_o[0][0] !== 16'd0 || window_o[1][0] !== 16'd0) begin
      n_fail++;
      $display("FAIL mid_frame_reset: got v=%b d=%b col=%0d row=%0d win={%h,%h} expected all 0",
               valid_o, frame_done_o, col_o, row_o, window_o[0][0], window_o[1][0]);
    end
    @(posedge clk_i);
    @(negedge clk_i);
    rst_i = 1'b1;
    m_active = 1'b0;
    idle(1);
    run_frame(4, 4, 0, 1'b0, "after_reset_4x4");
    idle(1);
  endtask

  task automatic test_back_to_back;
    run_frame(3, 2, 0, 1'b0, "b2b_first");
    run_frame(5, 4, 0, 1'b0, "b2b_second");
    idle(2);
  endtask

  task automatic test_random;
    for (int f = 0; f < 8; f++) begin
      run_frame($urandom_range(1, 12), $urandom_range(1, 6), $urandom_range(0, 2), 1'b0,
                "random");
      idle($urandom_range(0, 2));
    end
  endtask

  task automatic test_max_width;
    logic [15:0] last_col;
    run_frame(MAXW, 2, 0, 1'b0, "max_width");
    last_col = col_o;
    n_checks++;
    if (last_col !== 16'(MAXW - 1)) begin
      n_fail++;
      $display("FAIL max_width_last_col: got %0d expected %0d", last_col, MAXW - 1);
    end
    idle(2);
  endtask

`ifdef DSV_ROW_PAIR_SCHED_SEQ_CHK_EN
  task automatic raw_beat(input logic [15:0] c, input logic [15:0] r, input bit expect_err);
    valid_i = 1'b1; col_i = c; row_i = r; data_i = 16'($urandom);
    width_i = 16'd4; height_i = 16'd4;
    @(posedge clk_i);
    @(negedge clk_i);
    if (expect_err) begin
      n_checks++;
      if (error_o !== 1'b1 || valid_o !== 1'b0) begin
        n_fail++;
        $display("FAIL seq_error after (%0d,%0d): got err=%b v=%b expected err=1 v=0",
                 c, r, error_o, valid_o);
      end
    end
  endtask

  task automatic test_seq_error;
    for (int c = 0; c < 4; c++) raw_beat(16'(c), 16'd0, 1'b0);
    raw_beat(16'd0, 16'd1, 1'b0);
    raw_beat(16'd1, 16'd1, 1'b0);
    raw_beat(16'd3, 16'd1, 1'b1);
    for (int r = 2; r < 4; r++)
      for (int c = 0; c < 4; c++) raw_beat(16'(c), 16'(r), 1'b1);
    raw_beat(16'd0, 16'd0, 1'b1);
    valid_i = 1'b0;
    rst_i = 1'b0;
    #1;
    n_checks++;
    if (error_o !== 1'b0) begin
      n_fail++;
      $display("FAIL seq_error_reset: got %b expected 0", error_o);
    end
    @(negedge clk_i);
    rst_i = 1'b1;
    m_active = 1'b0;
    idle(1);
    run_frame(4, 4, 0, 1'b0, "after_error_4x4");
  endtask
`endif

  initial begin
    valid_i = 1'b0; col_i = '0; row_i = '0; data_i = '0;
    width_i = 16'd4; height_i = 16'd4;
    test_reset;
    test_frame_4x4;
    test_odd_height;
    test_toggle;
    test_idle_discard;
    test_reset_mid_frame;
    test_back_to_back;
    test_random;
    test_max_width;
`ifdef DSV_ROW_PAIR_SCHED_SEQ_CHK_EN
    test_seq_error;
`endif
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

endmodule
